// File: rtl/seven_segment_scan.sv
// seven_segment_scan: multiplexed 1..8 digit hex 7-segment driver with dwell/blank timing,
// leading-zero blanking and frame-latched shadow registers.
module seven_segment_scan #(
   parameter int DIGITS         = 2,
   parameter int DWELL_CYCLES   = 16,
   parameter int BLANK_CYCLES   = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  blank_lz,
   output logic [6:0]            seg,
   output logic                  seg_dp,
   output logic [DIGITS-1:0]     digit_sel,
   output logic                  frame_done
);
   localparam int CNT_BIG = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_BIG > 2 ? CNT_BIG : 2);
   localparam int IW      = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t                fsm_q, fsm_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*DIGITS-1:0]   val_q, val_d;
   logic [DIGITS-1:0]     dp_q, dp_d;
   logic                  lz_q, lz_d;
   logic                  advance, load, frame_end;
   logic [3:0]            nib;
   logic [6:0]            glyph, seg_on;
   logic [DIGITS-1:0]     sel_on;
   logic                  lit, blanked, dp_on;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q <= IDLE;
         idx_q <= '0;
         cnt_q <= '0;
         val_q <= '0;
         dp_q  <= '0;
         lz_q  <= 1'b0;
      end else begin
         fsm_q <= fsm_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         val_q <= val_d;
         dp_q  <= dp_d;
         lz_q  <= lz_d;
      end
   end

   always_comb begin
      fsm_d     = fsm_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      val_d     = val_q;
      dp_d      = dp_q;
      lz_d      = lz_q;
      advance   = 1'b0;
      load      = 1'b0;
      frame_end = 1'b0;
      if (!enable) begin
         fsm_d = IDLE;
      end else begin
         case (fsm_q)
            IDLE: begin
               load  = 1'b1;
               idx_d = '0;
               cnt_d = '0;
               fsm_d = SHOW;
            end
            SHOW: begin
               if (cnt_q != DWELL_LAST) cnt_d = cnt_q + 1'b1;
               else if (BLANK_CYCLES > 0) begin
                  fsm_d = BLANK;
                  cnt_d = '0;
               end else advance = 1'b1;
            end
            BLANK: begin
               if (cnt_q != BLANK_LAST) cnt_d = cnt_q + 1'b1;
               else advance = 1'b1;
            end
            default: fsm_d = IDLE;
         endcase
         if (advance) begin
            cnt_d = '0;
            fsm_d = SHOW;
            // wrap on an explicit last index so non-power-of-two digit counts never alias
            if (idx_q == IDX_LAST) begin
               idx_d     = '0;
               load      = 1'b1;
               frame_end = 1'b1;
            end else idx_d = idx_q + 1'b1;
         end
      end
      if (load) begin
         val_d = value;
         dp_d  = dp;
         lz_d  = blank_lz;
      end
   end

   always_comb begin
      nib = val_q[{idx_q, 2'b00} +: 4];
      case (nib)
         4'h0: glyph = 7'h7E;
         4'h1: glyph = 7'h30;
         4'h2: glyph = 7'h6D;
         4'h3: glyph = 7'h79;
         4'h4: glyph = 7'h33;
         4'h5: glyph = 7'h5B;
         4'h6: glyph = 7'h5F;
         4'h7: glyph = 7'h70;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h7B;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h1F;
         4'hC: glyph = 7'h4E;
         4'hD: glyph = 7'h3D;
         4'hE: glyph = 7'h4F;
         default: glyph = 7'h47;
      endcase
   end

   // a digit is a leading zero when it and every nibble above it are zero
   assign blanked    = lz_q && idx_q != '0 && (val_q >> {idx_q, 2'b00}) == '0;
   assign lit        = enable && fsm_q == SHOW;
   assign seg_on     = lit && !blanked ? glyph : 7'h00;
   assign dp_on      = lit && dp_q[idx_q];
   assign sel_on     = lit ? DIGITS'(1) << idx_q : '0;
   assign seg        = SEG_ACTIVE_LOW != 0 ? ~seg_on : seg_on;
   assign seg_dp     = SEG_ACTIVE_LOW != 0 ? !dp_on : dp_on;
   assign digit_sel  = SEL_ACTIVE_LOW != 0 ? ~sel_on : sel_on;
   assign frame_done = frame_end;
endmodule

// File: tb/tb_seven_segment_scan.sv
// tb_seven_segment_scan: three differently configured scanners checked against a
// time-index reference model, a vector table and directed corner sequences.
module tb_seven_segment_scan;
   localparam int DG [3]  = '{2, 4, 3};
   localparam int DWL [3] = '{16, 3, 1};
   localparam int BLK [3] = '{2, 1, 0};
   localparam bit SAL [3] = '{1'b1, 1'b0, 1'b1};
   localparam bit SLL [3] = '{1'b0, 1'b1, 1'b0};

   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, lz = 1'b0;
   logic [31:0] v = '0;
   logic [7:0]  dp = '0;
   logic [6:0]  seg0, seg1, seg2;
   logic        sdp0, sdp1, sdp2, fd0, fd1, fd2;
   logic [1:0]  sel0;
   logic [3:0]  sel1;
   logic [2:0]  sel2;

   int n_chk = 0, n_fail = 0;

   bit          m_run [3];
   int          m_t [3];
   logic [31:0] m_val [3];
   logic [7:0]  m_dp [3];
   bit          m_lz [3];

   string font_s [16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG", "ABC",
                          "ABCDEFG", "ABCDFG", "ABCEFG", "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};

   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  d;
      logic        lz;
      logic [1:0]  idx;
      logic [6:0]  seg;
      logic        dpx;
   } vec_t;
   vec_t tbl [24];

   always #5 clk = ~clk;

   seven_segment_scan u0 (.clk(clk), .rst_n(rst_n), .enable(enable), .value(v[7:0]), .dp(dp[1:0]),
      .blank_lz(lz), .seg(seg0), .seg_dp(sdp0), .digit_sel(sel0), .frame_done(fd0));
   seven_segment_scan #(.DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(0),
      .SEL_ACTIVE_LOW(1)) u1 (.clk(clk), .rst_n(rst_n), .enable(enable), .value(v[15:0]),
      .dp(dp[3:0]), .blank_lz(lz), .seg(seg1), .seg_dp(sdp1), .digit_sel(sel1), .frame_done(fd1));
   seven_segment_scan #(.DIGITS(3), .DWELL_CYCLES(1), .BLANK_CYCLES(0)) u2 (.clk(clk),
      .rst_n(rst_n), .enable(enable), .value(v[11:0]), .dp(dp[2:0]), .blank_lz(lz),
      .seg(seg2), .seg_dp(sdp2), .digit_sel(sel2), .frame_done(fd2));

   function automatic logic [6:0] font(input logic [3:0] n);
      logic [6:0] f = '0;
      string s = font_s[n];
      for (int i = 0; i < s.len(); i++) f[6 - int'(s[i] - 8'd65)] = 1'b1;
      return f;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic latch(input int k);
      m_val[k] = v & 32'((64'd1 << (4 * DG[k])) - 1);
      m_dp[k]  = dp & 8'((1 << DG[k]) - 1);
      m_lz[k]  = lz;
   endtask

   task automatic model_advance();
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) m_run[k] = 1'b0;
         else if (!m_run[k]) begin
            if (enable) begin
               m_run[k] = 1'b1;
               m_t[k] = 0;
               latch(k);
            end
         end else if (!enable) m_run[k] = 1'b0;
         else if (m_t[k] == DG[k] * (DWL[k] + BLK[k]) - 1) begin
            m_t[k] = 0;
            latch(k);
         end else m_t[k]++;
      end
   endtask

   task automatic model_check();
      logic [6:0] s, as;
      logic [7:0] sl, asl;
      logic sd, asd, f, af;
      logic [31:0] up;
      int l, p, d;
      for (int k = 0; k < 3; k++) begin
         l = DWL[k] + BLK[k];
         p = m_t[k];
         d = p / l;
         up = m_val[k] >> (4 * d);
         s = '0; sd = 1'b0; sl = '0; f = 1'b0;
         if (rst_n && m_run[k] && enable) begin
            if (p % l < DWL[k]) begin
               sl = 8'(1 << d);
               sd = m_dp[k][d];
               s = (m_lz[k] && d > 0 && up == 0) ? 7'h00 : font(up[3:0]);
            end
            f = (p == DG[k] * l - 1);
         end
         if (SAL[k]) begin
            s = ~s;
            sd = ~sd;
         end
         if (SLL[k]) sl = ~sl & 8'((1 << DG[k]) - 1);
         case (k)
            0: {as, asd, asl, af} = {seg0, sdp0, 6'b0, sel0, fd0};
            1: {as, asd, asl, af} = {seg1, sdp1, 4'b0, sel1, fd1};
            default: {as, asd, asl, af} = {seg2, sdp2, 5'b0, sel2, fd2};
         endcase
         n_chk++;
         if ({as, asd, asl, af} !== {s, sd, sl, f}) begin
            n_fail++;
            $display("FAIL model u%0d t=%0d seg/dp/sel/fd: got %h/%b/%h/%b expected %h/%b/%h/%b",
               k, m_t[k], as, asd, asl, af, s, sd, sl, f);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic restart(input logic [31:0] nv, input logic [7:0] nd, input logic nl);
      enable = 1'b0;
      step();
      v = nv;
      dp = nd;
      lz = nl;
      enable = 1'b1;
      step();
   endtask

   initial begin
      int first, period;
      logic [3:0] sel_exp;
      tbl = '{
         '{16'h0040, 4'h0, 1'b1, 2'd3, 7'h00, 1'b0}, '{16'h0040, 4'h0, 1'b1, 2'd2, 7'h00, 1'b0},
         '{16'h0040, 4'h0, 1'b1, 2'd1, 7'h33, 1'b0}, '{16'h0040, 4'h0, 1'b1, 2'd0, 7'h7E, 1'b0},
         '{16'h0000, 4'h2, 1'b1, 2'd1, 7'h00, 1'b1}, '{16'h0000, 4'h2, 1'b1, 2'd0, 7'h7E, 1'b0},
         '{16'h0000, 4'h0, 1'b0, 2'd3, 7'h7E, 1'b0}, '{16'h1234, 4'h0, 1'b1, 2'd3, 7'h30, 1'b0},
         '{16'h0B0D, 4'h8, 1'b1, 2'd3, 7'h00, 1'b1}, '{16'h0B0D, 4'h8, 1'b1, 2'd2, 7'h1F, 1'b0},
         '{16'h0B0D, 4'h8, 1'b1, 2'd1, 7'h7E, 1'b0}, '{16'h0B0D, 4'h8, 1'b1, 2'd0, 7'h3D, 1'b0},
         '{16'hCEF9, 4'h4, 1'b0, 2'd2, 7'h4F, 1'b1}, '{16'hCEF9, 4'h4, 1'b0, 2'd3, 7'h4E, 1'b0},
         '{16'hCEF9, 4'h4, 1'b0, 2'd1, 7'h47, 1'b0}, '{16'hCEF9, 4'h4, 1'b0, 2'd0, 7'h7B, 1'b0},
         '{16'h27A5, 4'h0, 1'b0, 2'd3, 7'h6D, 1'b0}, '{16'h27A5, 4'h0, 1'b0, 2'd2, 7'h70, 1'b0},
         '{16'h27A5, 4'h0, 1'b0, 2'd1, 7'h77, 1'b0}, '{16'h27A5, 4'h0, 1'b0, 2'd0, 7'h5B, 1'b0},
         '{16'h5678, 4'h1, 1'b0, 2'd0, 7'h7F, 1'b1}, '{16'h0006, 4'h0, 1'b1, 2'd0, 7'h5F, 1'b0},
         '{16'h0006, 4'h0, 1'b1, 2'd1, 7'h00, 1'b0}, '{16'h0000, 4'h0, 1'b1, 2'd3, 7'h00, 1'b0}};
      for (int k = 0; k < 3; k++) begin
         m_run[k] = 1'b0; m_t[k] = 0; m_val[k] = '0; m_dp[k] = '0; m_lz[k] = 1'b0;
      end
      repeat (2) step();
      chk("reset u0 seg", seg0, 7'h7F);
      chk("reset u0 dp", sdp0, 1'b1);
      chk("reset u0 sel", sel0, 2'b00);
      chk("reset u0 fd", fd0, 1'b0);
      chk("reset u1 seg", seg1, 7'h00);
      chk("reset u1 sel", sel1, 4'hF);
      rst_n = 1'b1;
      v = 32'h3A;
      dp = 8'b10;
      enable = 1'b1;
      step();
      chk("3A d0 seg", seg0, 7'h08);
      chk("3A d0 dp", sdp0, 1'b1);
      chk("3A d0 sel", sel0, 2'b01);
      chk("u2 sel0", sel2, 3'b001);
      chk("u2 fd0", fd2, 1'b0);
      step();
      chk("u2 sel1", sel2, 3'b010);
      chk("u2 fd1", fd2, 1'b0);
      step();
      chk("u2 sel2", sel2, 3'b100);
      chk("u2 fd2", fd2, 1'b1);
      step();
      chk("u2 sel wrap", sel2, 3'b001);
      repeat (13) step();
      chk("3A blank sel", sel0, 2'b00);
      chk("3A blank seg", seg0, 7'h7F);
      repeat (2) step();
      chk("3A d1 seg", seg0, 7'h06);
      chk("3A d1 dp", sdp0, 1'b0);
      chk("3A d1 sel", sel0, 2'b10);
      first = -1;
      period = 0;
      for (int i = 0; i < 100 && period == 0; i++) begin
         step();
         if (fd0) begin
            if (first < 0) first = i;
            else period = i - first;
         end
      end
      chk("frame period", period, 36);

      restart(32'h12, 8'h0, 1'b0);
      repeat (10) step();
      v = 32'h34;
      repeat (8) step();
      chk("mid old d1", seg0, 7'h4F);
      repeat (18) step();
      chk("mid new d0", seg0, 7'h4C);
      repeat (18) step();
      chk("mid new d1", seg0, 7'h06);

      repeat (2) step();
      enable = 1'b0;
      v = 32'h9C;
      #1;
      chk("en drop sel", sel0, 2'b00);
      chk("en drop seg", seg0, 7'h7F);
      chk("en drop dp", sdp0, 1'b1);
      step();
      enable = 1'b1;
      #1;
      chk("idle sel", sel0, 2'b00);
      step();
      chk("reenable seg", seg0, 7'h31);
      chk("reenable sel", sel0, 2'b01);

      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      chk("async rst seg", seg0, 7'h7F);
      chk("async rst sel", sel0, 2'b00);
      chk("async rst dp", sdp0, 1'b1);
      chk("async rst u1 sel", sel1, 4'hF);
      repeat (2) step();
      #2 rst_n = 1'b1;
      step();
      chk("post rst sel", sel0, 2'b01);
      chk("post rst seg", seg0, 7'h31);

      foreach (tbl[i]) begin
         restart({16'h0, tbl[i].v}, {4'h0, tbl[i].d}, tbl[i].lz);
         repeat (4 * int'(tbl[i].idx)) step();
         sel_exp = ~(4'b0001 << tbl[i].idx);
         chk($sformatf("tbl%0d seg", i), seg1, tbl[i].seg);
         chk($sformatf("tbl%0d dp", i), sdp1, tbl[i].dpx);
         chk($sformatf("tbl%0d sel", i), sel1, sel_exp);
      end

      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(7) == 0) v = $urandom >> $urandom_range(31);
         if ($urandom_range(7) == 0) dp = 8'($urandom);
         if ($urandom_range(15) == 0) lz = 1'($urandom);
         enable = $urandom_range(39) != 0;
         if ($urandom_range(599) == 0) begin
            #2 rst_n = 1'b0;
            repeat (2) step();
            #2 rst_n = 1'b1;
         end
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised multiplexed driver for common-anode/common-cathode 7-segment displays of 1–8 hex digits. It scans one digit at a time with a programmable dwell and an anti-ghosting blank interval. It adds per-digit decimal points, leading-zero blanking and tear-free frame-latched updates. It sits between the user datapath and the display PMOD pins. It replaces fixed 2-digit decoders in new designs.

## Interface
Parameters:
- DIGITS, 2, number of digits scanned (1..8); digit 0 is least significant.
- DWELL_CYCLES, 16, clocks each digit is lit (>=1).
- BLANK_CYCLES, 2, clocks all digits are off after each dwell (>=0; 0 disables blanking).
- SEG_ACTIVE_LOW, 1, 1: segment/dp outputs are 0 when lit.
- SEL_ACTIVE_LOW, 0, 1: digit_sel outputs are 0 when selected.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable.
- value  in  4*DIGITS  hex digits; nibble i = value[4i+3:4i].
- dp  in  DIGITS  decimal point request per digit.
- blank_lz  in  1  enable leading-zero blanking.
- seg  out  7  segments {A,B,C,D,E,F,G}, polarity per SEG_ACTIVE_LOW.
- seg_dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW.
- digit_sel  out  DIGITS  one-hot digit select, polarity per SEL_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- State registers: fsm (IDLE, SHOW, BLANK), digit index idx, cycle counter cnt, shadow registers val_q, dp_q, lz_q.
- IDLE: outputs inactive. On an edge with enable=1: load val_q<=value, dp_q<=dp, lz_q<=blank_lz; idx<=0, cnt<=0; go to SHOW.
- SHOW: digit idx is selected; seg and seg_dp are driven from val_q/dp_q nibble idx. cnt counts 0..DWELL_CYCLES-1.
  - At the last count, if BLANK_CYCLES>0, go to BLANK with cnt<=0.
  - Otherwise advance directly as in the BLANK exit below.
- BLANK: digit_sel, seg and seg_dp are all inactive. cnt counts 0..BLANK_CYCLES-1. At the last count, advance.
- Advance:
  - If idx<DIGITS-1: idx<=idx+1, go to SHOW.
  - Else: idx<=0, reload the shadow registers from the inputs, go to SHOW. frame_done=1 in that final cycle.
- enable=0 in SHOW or BLANK: outputs are forced inactive combinationally in the same cycle; fsm<=IDLE at the next edge. Re-enabling restarts at digit 0 with fresh shadows.
- Inputs change display only at frame boundaries. A mid-frame change of value/dp/blank_lz never produces a mixed frame.
- Hex font, lit segments:
  - 0=ABCDEF, 1=BC, 2=ABDEG, 3=ABCDG
  - 4=BCFG, 5=ACDFG, 6=ACDEFG, 7=ABC
  - 8=ABCDEFG, 9=ABCDFG, A=ABCEFG, b=CDEFG
  - C=ADEF, d=BCDEG, E=ADEFG, F=AEFG
- Leading-zero blanking: digit i (i>=1) shows no segments when lz_q=1, nibble i=0 and every nibble above i is 0.
  - Digit 0 is never blanked.
  - seg_dp of a blanked digit still follows dp_q[i].
  - The digit is still selected for its dwell, so the scan rate is constant.
- Polarity is applied at the output only; internal logic is active-high.

## Timing
- Reset (rst_n=0, asynchronous):
  - fsm=IDLE, idx=0, cnt=0, shadows=0.
  - seg and seg_dp all unlit: 7'h7F / 1 for the default polarity.
  - digit_sel all deselected: 0 for the default polarity.
  - frame_done=0.
- Reset deasserted mid-scan restarts from IDLE. No partial dwell or pulse is carried over.
- Latency:
  - With enable held high after rst_n rises: first edge loads the shadows, and digit 0 is lit from the cycle after that edge.
  - Input-to-display latency is at most one frame plus 1 cycle.
- Frame length is DIGITS*(DWELL_CYCLES+BLANK_CYCLES) cycles. The first frame after IDLE adds 1 IDLE cycle.
- Exactly one digit_sel bit is active in SHOW; none are active in IDLE or BLANK.
- frame_done is high exactly once per frame: in the final SHOW cycle when BLANK_CYCLES=0, otherwise the final BLANK cycle, of digit DIGITS-1.
- Outputs are combinational from registered state plus the enable gate. No other input reaches the outputs combinationally.
- cnt width is clog2(max(DWELL_CYCLES,BLANK_CYCLES,2)). idx wraps only via the advance rule, with no modulo-2^n aliasing for non-power-of-two DIGITS.

## Test plan
- Defaults, value=8'h3A, dp=2'b10, enable=1 -> digit0 lit 16 cycles (A=ABCEFG, dp off), 2 blank cycles, then digit1 (3=ABCDG, dp on); frame_done pulses every 36 cycles.
- DIGITS=4, blank_lz=1, value=16'h0040 -> digits 3 and 2 dark but scanned, digit1=4 (BCFG), digit0=0 (ABCDEF); value=16'h0000 -> only digit0 shows 0.
- Change value from 8'h12 to 8'h34 mid-frame (cycle 10 of digit0) -> remainder of frame shows 1/2 unchanged; next frame shows 3/4.
- BLANK_CYCLES=0, DIGITS=3, DWELL_CYCLES=1 -> digit_sel cycles 001,010,100 back-to-back; frame_done high every 3rd cycle.
- Drop enable for 1 cycle during digit1 dwell -> outputs inactive that cycle, 1 IDLE cycle, restart at digit0 with re-latched value.
- Assert rst_n=0 asynchronously mid-dwell, between clock edges -> all outputs go inactive immediately; after release, scan resumes from digit0 per the latency rule.
